// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory handshake,
// holds the fetched instruction for execute and resolves the next PC on completion.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_o,
   output logic [5:0]  opcode_o,
   output logic [5:0]  func_o,
   output logic        instr_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] link_addr_o,
   input  logic        exec_done_i,
   input  logic        halted_i,
   input  logic        branch_i,
   input  logic        branch_taken_i,
   input  logic        jump_i,
   input  logic        jump_register_i,
   input  logic [31:0] jr_target_i,
   output logic        halt_out_o,
   output logic        fault_o,
   output logic [31:0] retired_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_e;

   state_e      state_q;
   logic        armed_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] retired_q;
   logic        mem_req_q;
   logic        instr_valid_q;
   logic        halt_q;
   logic        fault_q;

   logic [31:0] link_addr;
   logic [31:0] pc_d;
   logic        jr_misaligned;

   assign link_addr     = pc_q + 32'd4;
   assign jr_misaligned = jump_register_i && (jr_target_i[1:0] != 2'b00);

   // Next-PC selection for the non-halting outcomes, highest priority first.
   always_comb begin
      pc_d = link_addr;
      if (jump_register_i) begin
         pc_d = jr_target_i;
      end else if (jump_i) begin
         pc_d = {link_addr[31:28], instr_q[25:0], 2'b00};
      end else if (branch_i && branch_taken_i) begin
         pc_d = link_addr + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      end else begin
         pc_d = link_addr;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         armed_q       <= 1'b0;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0000_0000;
         retired_q     <= 32'h0000_0000;
         mem_req_q     <= 1'b0;
         instr_valid_q <= 1'b0;
         halt_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         case (state_q)
            // The first edge after reset release only arms the start.
            IDLE: begin
               if (armed_q) begin
                  state_q   <= FETCH;
                  mem_req_q <= 1'b1;
               end else begin
                  armed_q <= 1'b1;
               end
            end
            FETCH: begin
               if (mem_ready_i) begin
                  instr_q       <= mem_rdata_i;
                  mem_req_q     <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= ISSUE;
               end
            end
            ISSUE: begin
               if (exec_done_i) begin
                  retired_q     <= retired_q + 32'd1;
                  instr_valid_q <= 1'b0;
                  if (halted_i) begin
                     halt_q  <= 1'b1;
                     state_q <= HALT;
                  end else if (jr_misaligned) begin
                     fault_q <= 1'b1;
                     halt_q  <= 1'b1;
                     state_q <= HALT;
                  end else begin
                     pc_q      <= pc_d;
                     mem_req_q <= 1'b1;
                     state_q   <= FETCH;
                  end
               end
            end
            HALT: begin
               mem_req_q     <= 1'b0;
               instr_valid_q <= 1'b0;
               halt_q        <= 1'b1;
            end
            default: begin
               state_q       <= IDLE;
               armed_q       <= 1'b0;
               mem_req_q     <= 1'b0;
               instr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req_o     = mem_req_q;
   assign mem_addr_o    = pc_q;
   assign instr_o       = instr_q;
   assign opcode_o      = instr_q[31:26];
   assign func_o        = instr_q[5:0];
   assign instr_valid_o = instr_valid_q;
   assign pc_o          = pc_q;
   assign link_addr_o   = link_addr;
   assign halt_out_o    = halt_q;
   assign fault_o       = fault_q;
   assign retired_o     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard queue of expected fetch addresses
// is filled as control outcomes are driven and drained as the DUT requests memory.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] link_addr;
   logic        exec_done;
   logic        halted;
   logic        branch;
   logic        branch_taken;
   logic        jump;
   logic        jump_register;
   logic [31:0] jr_target;
   logic        halt_out;
   logic        fault;
   logic [31:0] retired;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          c0;
   logic [31:0] exp_q [$];

   localparam logic [31:0] ADDIU = 32'h2401_0001;

   fetch_unit dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .mem_req_o       (mem_req),
      .mem_addr_o      (mem_addr),
      .mem_ready_i     (mem_ready),
      .mem_rdata_i     (mem_rdata),
      .instr_o         (instr),
      .opcode_o        (opcode),
      .func_o          (func),
      .instr_valid_o   (instr_valid),
      .pc_o            (pc),
      .link_addr_o     (link_addr),
      .exec_done_i     (exec_done),
      .halted_i        (halted),
      .branch_i        (branch),
      .branch_taken_i  (branch_taken),
      .jump_i          (jump),
      .jump_register_i (jump_register),
      .jr_target_i     (jr_target),
      .halt_out_o      (halt_out),
      .fault_o         (fault),
      .retired_o       (retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic clear_ctrl();
      exec_done     = 1'b0;
      halted        = 1'b0;
      branch        = 1'b0;
      branch_taken  = 1'b0;
      jump          = 1'b0;
      jump_register = 1'b0;
      jr_target     = 32'h0000_0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_halt", halt_out, 1'b0);
      chk1("rst_fault", fault, 1'b0);
      chk("rst_retired", retired, 32'h0000_0000);
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_addr", mem_addr, 32'h0000_0000);
      chk("rst_instr", instr, 32'h0000_0000);
      chk("rst_link", link_addr, 32'h0000_0004);
      chk("rst_opfunc", {20'd0, opcode, func}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      @(negedge clk);
      chk1("boot_idle_req", mem_req, 1'b0);
      @(negedge clk);
      chk1("boot_fetch_req", mem_req, 1'b1);
   endtask

   task automatic do_fetch(input int wait_n, input logic [31:0] word);
      logic [31:0] exp_addr;
      int          guard;
      guard = 0;
      while (mem_req !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk1("fetch_req", mem_req, 1'b1);
      exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("fetch_addr", mem_addr, exp_addr);
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk1("wait_req", mem_req, 1'b1);
         chk("wait_addr", mem_addr, exp_addr);
         chk1("wait_valid", instr_valid, 1'b0);
      end
      mem_ready = 1'b1;
      mem_rdata = word;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0000_0000;
      chk1("issue_valid", instr_valid, 1'b1);
      chk("issue_instr", instr, word);
      chk("issue_opfunc", {20'd0, opcode, func}, {20'd0, word[31:26], word[5:0]});
      chk("issue_pc", pc, exp_addr);
      chk1("issue_req", mem_req, 1'b0);
   endtask

   task automatic do_exec(input logic h, input logic br, input logic bt, input logic j,
                          input logic jr, input logic [31:0] tgt);
      exec_done     = 1'b1;
      halted        = h;
      branch        = br;
      branch_taken  = bt;
      jump          = j;
      jump_register = jr;
      jr_target     = tgt;
      @(negedge clk);
      clear_ctrl();
      chk1("exec_valid_drop", instr_valid, 1'b0);
   endtask

   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0000_0000;
      clear_ctrl();
      do_reset();

      // Sequential stream with zero-wait memory: one instruction per two cycles.
      c0 = cyc;
      for (int i = 0; i < 4; i++) begin
         do_fetch(0, ADDIU);
         do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         exp_q.push_back(32'(i + 1) * 32'd4);
      end
      chk("seq_retired", retired, 32'd4);
      chk("seq_cycles", 32'(cyc - c0), 32'd8);

      // Three wait cycles at 0x10, then a spurious mem_ready during issue.
      do_fetch(3, 32'h2402_0002);
      mem_ready = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("spurious_instr", instr, 32'h2402_0002);
      chk1("spurious_valid", instr_valid, 1'b1);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
      exp_q.push_back(32'h0000_0020);

      // Branch taken/not-taken with imm = -1 and a direct jump.
      do_fetch(0, 32'h1000_FFFF);
      do_exec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0020);
      do_fetch(0, 32'h1000_FFFF);
      do_exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0024);
      do_fetch(0, 32'h0800_0040);
      do_exec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0100);

      // Control inputs without exec_done are ignored; then jr wins priority.
      do_fetch(0, 32'h0000_0008);
      jump          = 1'b1;
      jump_register = 1'b1;
      jr_target     = 32'h0000_0202;
      @(negedge clk);
      clear_ctrl();
      chk1("noexec_fault", fault, 1'b0);
      chk1("noexec_valid", instr_valid, 1'b1);
      chk("noexec_pc", pc, 32'h0000_0100);
      do_exec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
      exp_q.push_back(32'h0000_0200);

      // PC wrap from FFFF_FFFC.
      do_fetch(0, 32'h0000_0008);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      exp_q.push_back(32'hFFFF_FFFC);
      do_fetch(0, ADDIU);
      chk("wrap_link", link_addr, 32'h0000_0000);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0000);
      do_fetch(0, ADDIU);

      // Retired counter wrap.
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      chk("preload_retired", retired, 32'hFFFF_FFFF);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wrap_retired", retired, 32'h0000_0000);
      exp_q.push_back(32'h0000_0004);
      do_fetch(0, 32'h0000_0008);

      // Misaligned jump_register target faults and halts.
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0202);
      chk1("fault_set", fault, 1'b1);
      chk1("fault_halt", halt_out, 1'b1);
      chk1("fault_req", mem_req, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk1("fault_hold_req", mem_req, 1'b0);
         chk1("fault_hold", fault, 1'b1);
      end

      // Restart, then syscall at 0x8 with jump also asserted.
      do_reset();
      do_fetch(0, ADDIU);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0004);
      do_fetch(0, ADDIU);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_q.push_back(32'h0000_0008);
      do_fetch(0, 32'h0000_000C);
      do_exec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk1("sys_halt", halt_out, 1'b1);
      chk1("sys_fault", fault, 1'b0);
      chk("sys_pc", pc, 32'h0000_0008);
      chk("sys_retired", retired, 32'd3);
      mem_ready = 1'b1;
      mem_rdata = 32'h1111_1111;
      exec_done = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk1("sys_hold_req", mem_req, 1'b0);
         chk1("sys_hold_valid", instr_valid, 1'b0);
      end
      mem_ready = 1'b0;
      exec_done = 1'b0;
      chk("sys_hold_instr", instr, 32'h0000_000C);
      chk("sys_hold_retired", retired, 32'd3);

      // Reset pulsed mid-FETCH with a late mem_ready.
      do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk1("midfetch_req", mem_req, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h1234_5678;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'h0000_0000;
      chk1("late_ready_valid", instr_valid, 1'b0);
      chk("late_ready_instr", instr, 32'h0000_0000);
      exp_q.delete();
      exp_q.push_back(32'h0000_0000);
      do_fetch(1, ADDIU);
      do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("restart_retired", retired, 32'd1);
      chk("restart_pc", pc, 32'h0000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Front-end stage of the processor: fetches the instruction that feeds the control unit and the datapath.
- Holds the PC and drives a request/ready instruction-memory handshake.
- Presents the instruction with its opcode and func fields, then waits for execute to finish.
- At completion it samples the control unit's branch, jump, jump_register and halted outputs, computes the next PC, and either fetches again or halts.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  instruction-memory read request.
- mem_addr  out  32  word-aligned fetch address; equals pc.
- mem_ready  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  32  instruction word.
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- func  out  6  instr[5:0].
- instr_valid  out  1  instr is valid and awaiting execution.
- pc  out  32  address of the current instruction.
- link_addr  out  32  pc + 4; write-back value for link instructions.
- exec_done  in  1  execute finished the current instruction; control inputs are valid this cycle.
- halted  in  1  control-unit halt request (syscall).
- branch  in  1  instruction is a conditional branch.
- branch_taken  in  1  branch condition true.
- jump  in  1  direct jump.
- jump_register  in  1  register-indirect jump.
- jr_target  in  32  register value for jump_register.
- halt_out  out  1  core has stopped fetching.
- fault  out  1  misaligned jump_register target detected.
- retired  out  32  count of completed instructions.

## Operation
- States: IDLE, FETCH, ISSUE, HALT. Reset enters IDLE.
- IDLE: one cycle, then FETCH.
- FETCH:
  - mem_req = 1 and mem_addr = pc, both held stable until mem_ready.
  - On mem_ready: instr <= mem_rdata, go to ISSUE.
- ISSUE:
  - instr_valid = 1, and instr and pc are held stable until exec_done.
  - On exec_done: retired <= retired + 1, wrapping modulo 2^32.
  - Next-PC priority, highest first:
    1. halted: go to HALT; pc is unchanged.
    2. jump_register with jr_target[1:0] != 0: fault <= 1, go to HALT.
    3. jump_register: pc <= jr_target.
    4. jump: pc <= {link_addr[31:28], instr[25:0], 2'b00}.
    5. branch & branch_taken: pc <= link_addr + (sign-extended instr[15:0] << 2).
    6. Otherwise: pc <= link_addr.
  - After cases 3-6, go to FETCH.
- HALT: absorbing. halt_out = 1, mem_req = 0, instr_valid = 0. Only rst leaves HALT.
- Ignored inputs:
  - mem_ready outside FETCH.
  - exec_done outside ISSUE.
  - Control inputs when exec_done = 0.
- Arithmetic: all PC arithmetic is 32-bit and wraps modulo 2^32 (pc = FFFF_FFFC plus 4 gives 0). There are no delay slots.
- Reset values: pc = RESET_PC, instr = 0, mem_req = 0, instr_valid = 0, halt_out = 0, fault = 0, retired = 0. opcode, func, link_addr and mem_addr follow from these.

## Timing
- All outputs are registered or decoded from registered state.
- Combinational input-to-output paths: none.
- Reset:
  - Deasserted before edge 0: mem_req rises after edge 1 (IDLE then FETCH).
  - Asserted mid-FETCH or mid-ISSUE: all outputs drop to reset values immediately. The outstanding request is abandoned and any late mem_ready is ignored.
- Fetch: mem_ready sampled at edge N gives instr_valid = 1 and the new instr after edge N.
  - mem_ready may arrive in the first FETCH cycle, so minimum fetch latency is 1 cycle.
- Issue: exec_done sampled at edge M gives instr_valid = 0 and the updated pc after edge M. The next mem_req is high in the same cycle.
- Minimum per-instruction period is 2 cycles (FETCH + ISSUE) with zero-wait memory and immediate exec_done.
- halt_out and fault rise together after the exec_done edge and hold until rst.

## Test plan
- Sequential ADDIU stream, RESET_PC = 0, zero-wait memory and immediate exec_done:
  - mem_addr sequence is 0, 4, 8, C.
  - retired = 4 after 4 exec_done.
  - One instruction every 2 cycles.
- Memory wait of 3 cycles at addr 0x10:
  - mem_req and mem_addr stay stable for 3 cycles.
  - instr_valid rises the cycle after mem_ready.
  - A spurious mem_ready during ISSUE does not change instr.
- Branches at pc = 0x20 with imm = 0xFFFF:
  - taken: next mem_addr = 0x20.
  - not taken: next mem_addr = 0x24.
  - jump with instr[25:0] = 0x40: next mem_addr = 0x100.
- Priority and faults:
  - jump, jump_register and branch_taken all high with jr_target = 0x200: next pc = 0x200.
  - jr_target = 0x202: fault = 1 and halt_out = 1.
- Syscall at pc = 0x8 with halted = 1 together with jump = 1:
  - halt_out = 1 and pc stays 0x8; mem_req stays 0 forever.
  - retired increments once.
  - rst then restarts at RESET_PC.
- Boundary cases:
  - rst pulsed mid-FETCH: mem_req drops asynchronously and the late mem_ready is ignored.
  - pc = FFFF_FFFC, sequential: next mem_addr = 0.
  - retired preloaded to FFFF_FFFF: wraps to 0.
